// File: rtl/pwm_capture_pkg.sv
// pwm_capture shared types and defaults.
// FSM encoding and parameter defaults for the capture path.
package pwm_capture_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int DUTY_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

endpackage

// File: rtl/pwm_div.sv
// Restoring divider, one quotient bit per cycle.
// Computes (dividend << QW) / divisor assuming dividend < divisor.
module pwm_div #(
  parameter int NW = 16,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] dividend,
  input  logic [NW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(QW + 1);

  logic [NW:0]   rem_q;
  logic [NW:0]   rem_sh;
  logic [NW:0]   rem_d;
  logic [NW-1:0] div_q;
  logic [QW-1:0] quo_q;
  logic [QW-1:0] quo_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          ge;
  logic          last;

  // Remainder stays below divisor, so the shift never loses bit NW.
  always_comb begin
    rem_sh = {rem_q[NW-1:0], 1'b0};
    ge     = rem_sh >= {1'b0, div_q};
    rem_d  = ge ? rem_sh - {1'b0, div_q} : rem_sh;
    quo_d  = {quo_q[QW-2:0], ge};
  end

  assign last     = cnt_q == CW'(1);
  assign busy     = busy_q;
  assign done     = busy_q & last & ~abort;
  assign quotient = quo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= {1'b0, dividend};
      div_q  <= divisor;
      quo_q  <= '0;
      cnt_q  <= CW'(QW);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= !last;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM duty/period/direction capture on the A/B driver pair.
// One result per closed period; stall and A/B conflict flagged.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pwm_inA,
  input  logic              pwm_inB,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              direction,
  output logic              valid,
  output logic              stalled,
  output logic              fault
);

  logic a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic s_q, conf_q;
  logic s, rise, fall, conf, tmo, ovr;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  per_q, per_d, hi_q, hi_d;
  logic [CNT_W-1:0]  pper_q, pper_d, phi_q, phi_d;
  logic              dnx_q, dnx_d, pdir_q, pdir_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              dir_q, dir_d;
  logic              valid_q, valid_d;
  logic              stall_q, stall_d;
  logic              fault_q, fault_d;

  logic              dv_start, dv_abort;
  logic              dv_busy, dv_done;
  logic [DUTY_W-1:0] dv_quo;

  assign s    = a_s2_q | b_s2_q;
  assign conf = a_s2_q & b_s2_q;
  assign rise = s & ~s_q;
  assign fall = ~s & s_q;
  assign tmo  = per_q == CNT_W'(TIMEOUT);
  // Publish cycle also blocks a new start: keeps min period DUTY_W+2.
  assign ovr  = dv_busy | valid_q;

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    pper_d   = pper_q;
    phi_d    = phi_q;
    dnx_d    = dnx_q;
    pdir_d   = pdir_q;
    duty_d   = duty_q;
    period_d = period_q;
    high_d   = high_q;
    dir_d    = dir_q;
    stall_d  = stall_q;
    valid_d  = 1'b0;
    fault_d  = 1'b0;
    dv_start = 1'b0;
    dv_abort = 1'b0;
    if (!enable) begin
      state_d  = ST_IDLE;
      per_d    = '0;
      hi_d     = '0;
      dv_abort = 1'b1;
    end else if (conf) begin
      state_d  = ST_IDLE;
      dv_abort = 1'b1;
      fault_d  = ~conf_q;
    end else begin
      if (dv_done) begin
        duty_d   = dv_quo;
        period_d = pper_q;
        high_d   = phi_q;
        dir_d    = pdir_q;
        valid_d  = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HIGH;
            per_d   = CNT_W'(1);
            hi_d    = CNT_W'(1);
            dnx_d   = a_s2_q;
            stall_d = 1'b0;
          end
        end
        ST_HIGH, ST_LOW: begin
          if (tmo) begin
            state_d = ST_IDLE;
            stall_d = 1'b1;
            duty_d  = {DUTY_W{s}};
            valid_d = 1'b1;
          end else if (state_q == ST_HIGH && fall) begin
            state_d = ST_LOW;
            per_d   = per_q + CNT_W'(1);
          end else if (state_q == ST_LOW && rise) begin
            state_d = ST_HIGH;
            per_d   = CNT_W'(1);
            hi_d    = CNT_W'(1);
            dnx_d   = a_s2_q;
            if (!ovr) begin
              dv_start = 1'b1;
              pper_d   = per_q;
              phi_d    = hi_q;
              pdir_d   = dnx_q;
            end
          end else begin
            per_d = per_q + CNT_W'(1);
            if (state_q == ST_HIGH) hi_d = hi_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q   <= 1'b0;
      a_s2_q   <= 1'b0;
      b_s1_q   <= 1'b0;
      b_s2_q   <= 1'b0;
      s_q      <= 1'b0;
      conf_q   <= 1'b0;
      state_q  <= ST_IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      pper_q   <= '0;
      phi_q    <= '0;
      dnx_q    <= 1'b0;
      pdir_q   <= 1'b0;
      duty_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      a_s1_q   <= pwm_inA;
      a_s2_q   <= a_s1_q;
      b_s1_q   <= pwm_inB;
      b_s2_q   <= b_s1_q;
      s_q      <= s;
      conf_q   <= conf;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      pper_q   <= pper_d;
      phi_q    <= phi_d;
      dnx_q    <= dnx_d;
      pdir_q   <= pdir_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      high_q   <= high_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
      fault_q  <= fault_d;
    end
  end

  pwm_div #(
    .NW (CNT_W),
    .QW (DUTY_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dv_start),
    .abort    (dv_abort),
    .dividend (hi_q),
    .divisor  (per_q),
    .busy     (dv_busy),
    .done     (dv_done),
    .quotient (dv_quo)
  );

  assign duty      = duty_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign direction = dir_q;
  assign valid     = valid_q;
  assign stalled   = stall_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture.
// Table of steady PWM patterns plus stall/fault/enable/reset sequences.
module tb_pwm_capture;

  localparam int CW = 16;
  localparam int DW = 8;
  localparam int TO = 1024;
  localparam int LAT = DW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pwm_inA = 1'b0;
  logic          pwm_inB = 1'b0;
  logic [DW-1:0] duty;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          direction;
  logic          valid;
  logic          stalled;
  logic          fault;

  pwm_capture #(
    .CNT_W   (CW),
    .DUTY_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .pwm_inA   (pwm_inA),
    .pwm_inB   (pwm_inB),
    .duty      (duty),
    .period    (period),
    .high_time (high_time),
    .direction (direction),
    .valid     (valid),
    .stalled   (stalled),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sel_a;
    int hi;
    int per;
    int e_duty;
    int e_dir;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;

  int ph = 0;
  int per_len = 256;
  int hi_len = 64;
  bit sel_a = 1'b1;
  bit gen_on = 1'b0;
  bit fa = 1'b0;
  bit fb = 1'b0;
  bit bpulse = 1'b0;
  bit prev_valid = 1'b0;
  int vcnt = 0;
  int fcnt = 0;
  int last_ph = -1;
  int last_duty = -1;
  int last_per = -1;
  int last_hi = -1;
  int last_dir = -1;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (gen_on) begin
      pwm_inA = sel_a && (ph < hi_len);
      pwm_inB = (!sel_a && (ph < hi_len)) || bpulse;
    end else begin
      pwm_inA = fa;
      pwm_inB = fb || bpulse;
    end
    if (valid) begin
      vcnt++;
      last_ph   = ph;
      last_duty = int'(duty);
      last_per  = int'(period);
      last_hi   = int'(high_time);
      last_dir  = int'(direction);
      chk("valid_width", int'(prev_valid), 0);
      chk("valid_vs_fault", int'(fault), 0);
    end
    if (fault) fcnt++;
    prev_valid = valid;
    ph = (ph + 1) % per_len;
  endtask

  task automatic run_to(input int p);
    int n;
    n = 0;
    while (ph != p && n < 4000) begin
      step();
      n++;
    end
  endtask

  task automatic start_gen(input bit a, input int h, input int p);
    sel_a   = a;
    hi_len  = h;
    per_len = p;
    ph      = 0;
    gen_on  = 1'b1;
  endtask

  task automatic wait_valids(input string name, input int k,
                             input int budget);
    int v0;
    int n;
    v0 = vcnt;
    n  = 0;
    while (vcnt < v0 + k && n < budget) begin
      step();
      n++;
    end
    chk(name, vcnt - v0, k);
  endtask

  initial begin
    int v0;
    int f0;

    vecs[0] = '{1'b1,  64, 256,  64, 1};
    vecs[1] = '{1'b0, 128, 256, 128, 0};
    vecs[2] = '{1'b1, 128, 256, 128, 1};
    vecs[3] = '{1'b1, 100, 300,  85, 1};
    vecs[4] = '{1'b0,  30,  40, 192, 0};
    vecs[5] = '{1'b1,   1,  10,  25, 1};
    vecs[6] = '{1'b1, 255, 256, 255, 1};
    vecs[7] = '{1'b1,   7,  13, 137, 1};

    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_dir", int'(direction), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stalled", int'(stalled), 0);
    chk("rst_fault", int'(fault), 0);
    rst_n  = 1'b1;
    enable = 1'b1;

    foreach (vecs[i]) begin
      start_gen(vecs[i].sel_a, vecs[i].hi, vecs[i].per);
      wait_valids($sformatf("v%0d_count", i), 3,
                  4 * vecs[i].per + 100);
      chk($sformatf("v%0d_duty", i), last_duty, vecs[i].e_duty);
      chk($sformatf("v%0d_period", i), last_per, vecs[i].per);
      chk($sformatf("v%0d_high", i), last_hi, vecs[i].hi);
      chk($sformatf("v%0d_dir", i), last_dir, vecs[i].e_dir);
      chk($sformatf("v%0d_latency", i), last_ph,
          LAT % vecs[i].per);
    end

    // Stall low, then stall high, then clear on a rising edge.
    start_gen(1'b1, 64, 256);
    wait_valids("stl_pre", 2, 1200);
    gen_on = 1'b0;
    fa = 1'b0;
    fb = 1'b0;
    v0 = vcnt;
    repeat (1100) step();
    chk("stl_lo_valids", vcnt - v0, 1);
    chk("stl_lo_flag", int'(stalled), 1);
    chk("stl_lo_duty", int'(duty), 0);
    chk("stl_lo_period", int'(period), 256);
    chk("stl_lo_high", int'(high_time), 64);
    fa = 1'b1;
    v0 = vcnt;
    repeat (10) step();
    chk("stl_clr1", int'(stalled), 0);
    repeat (1100) step();
    chk("stl_hi_valids", vcnt - v0, 1);
    chk("stl_hi_flag", int'(stalled), 1);
    chk("stl_hi_duty", int'(duty), 255);
    fa = 1'b0;
    repeat (10) step();
    chk("stl_hold", int'(stalled), 1);
    fa = 1'b1;
    repeat (10) step();
    chk("stl_clr2", int'(stalled), 0);

    // One-cycle A/B conflict in the middle of a high phase.
    start_gen(1'b1, 64, 256);
    wait_valids("flt_pre", 3, 1200);
    run_to(30);
    f0 = fcnt;
    v0 = vcnt;
    bpulse = 1'b1;
    step();
    bpulse = 1'b0;
    run_to(0);
    run_to(20);
    chk("flt_pulses", fcnt - f0, 1);
    chk("flt_no_valid", vcnt - v0, 0);
    run_to(0);
    run_to(20);
    chk("flt_resume", vcnt - v0, 1);
    chk("flt_duty", last_duty, 64);

    // Enable dropped for 50 cycles mid-period.
    start_gen(1'b0, 128, 256);
    wait_valids("en_pre", 3, 1200);
    start_gen(1'b1, 64, 256);
    wait_valids("en_pre2", 3, 1200);
    run_to(100);
    enable = 1'b0;
    v0 = vcnt;
    repeat (50) step();
    chk("en_low_valids", vcnt - v0, 0);
    chk("en_low_duty", int'(duty), 64);
    chk("en_low_period", int'(period), 256);
    chk("en_low_dir", int'(direction), 1);
    enable = 1'b1;
    run_to(0);
    run_to(20);
    chk("en_first_period", vcnt - v0, 0);
    run_to(0);
    run_to(20);
    chk("en_resume", vcnt - v0, 1);
    chk("en_duty", last_duty, 64);

    // Reset while the divider is working.
    run_to(0);
    run_to(4);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("mr_duty", int'(duty), 0);
    chk("mr_period", int'(period), 0);
    chk("mr_high", int'(high_time), 0);
    chk("mr_dir", int'(direction), 0);
    chk("mr_valid", int'(valid), 0);
    chk("mr_stalled", int'(stalled), 0);
    v0 = vcnt;
    run_to(74);
    rst_n = 1'b1;
    run_to(0);
    run_to(20);
    chk("mr_quiet", vcnt - v0, 0);
    run_to(0);
    run_to(20);
    chk("mr_resume", vcnt - v0, 1);
    chk("mr_res_duty", last_duty, 64);
    chk("mr_res_dir", last_dir, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
